ghost_typist: RTL and testbench

//  Keystroke generator for the ghost opponent and demo mode. Takes a dictionary word (15x5-bit letter indices)
//  and emits a paced stream of keyboard events (press/release of the matching set-2 scan codes, then space).

---
 rtl/typeracer_pkg.sv | 35 +++
 rtl/letter_to_scancode.sv | 23 ++
 rtl/ghost_typist.sv | 233 +++++++++++++++++++++++
 tb/tb_ghost_typist.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/typeracer_pkg.sv
// ============================================================================
// typeracer_pkg: scan-code table and ghost typist types shared with the game counter.  Rev 1.0
// ============================================================================
`default_nettype none

package typeracer_pkg;

  // Set-2 make codes, indexed by letter number; entry 0 is the "no letter" slot.
  localparam logic [8:0] KEY [0:26] = '{
    9'd0,
    9'd28, 9'd50, 9'd33, 9'd35, 9'd36, 9'd43, 9'd52, 9'd51, 9'd67,
    9'd59, 9'd66, 9'd75, 9'd58, 9'd49, 9'd68, 9'd77, 9'd21, 9'd45,
    9'd27, 9'd44, 9'd60, 9'd42, 9'd29, 9'd34, 9'd53, 9'd26
  };

  localparam logic [8:0] BACK  = 9'd102;
  localparam logic [8:0] SPACE = 9'd41;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_GAP  = 2'd3
  } ghost_state_t;

  typedef enum logic [1:0] {
    KK_LETTER = 2'd0,
    KK_WRONG  = 2'd1,
    KK_BACK   = 2'd2,
    KK_SPACE  = 2'd3
  } key_kind_t;

endpackage

`default_nettype wire

// File: rtl/letter_to_scancode.sv
// ============================================================================
// letter_to_scancode: 5-bit letter index (1..26) to 9-bit set-2 code plus valid flag.  Rev 1.0
// ============================================================================
`default_nettype none

module letter_to_scancode
  import typeracer_pkg::*;
(
  input  logic [4:0] i_idx,
  output logic [8:0] o_code,
  output logic       o_valid
);

  logic [4:0] w_idx;

  assign o_valid = (i_idx != 5'd0) && (i_idx <= 5'd26);
  // Out-of-table indices fold onto entry 0 so the lookup never leaves the table.
  assign w_idx   = o_valid ? i_idx : 5'd0;
  assign o_code  = KEY[w_idx];

endmodule

`default_nettype wire

// File: rtl/ghost_typist.sv
// ============================================================================
// ghost_typist: paced press/release keystroke generator for ghost and demo modes.  Rev 1.0
// ============================================================================
`default_nettype none

module ghost_typist
  import typeracer_pkg::*;
#(
  parameter int HOLD_TICKS     = 3,
  parameter int GAP_TICKS      = 5,
  parameter int MISTAKE_PERIOD = 8,
  parameter int MAX_LETTERS    = 15
)(
  input  logic                     clk_div,
  input  logic                     rst,
  input  logic                     i_enable,
  input  logic [5*MAX_LETTERS-1:0] i_word,
  input  logic [4:0]               i_wordnum,
  input  logic                     i_word_valid,
  input  logic                     i_mistake_en,
  output logic                     o_word_taken,
  output logic [127:0]             o_key_down,
  output logic [8:0]               o_last_change,
  output logic                     o_key_valid,
  output logic [3:0]               o_letter_idx,
  output logic                     o_word_done,
  output logic                     o_busy
);

  localparam int         SW      = $clog2(MAX_LETTERS);
  localparam logic [7:0] HOLD_M1 = 8'(HOLD_TICKS - 1);
  localparam logic [7:0] GAP_M1  = 8'(GAP_TICKS - 1);
  localparam logic [7:0] MC_LAST = 8'(MISTAKE_PERIOD - 1);
  localparam logic [4:0] NUM_MAX = 5'(MAX_LETTERS);

  ghost_state_t               r_state, w_state_nx;
  key_kind_t                  r_kind, w_kind_nx;
  logic [7:0]                 r_cnt, w_cnt_nx;
  logic [7:0]                 r_mcnt, w_mcnt_nx;
  logic [4:0]                 r_ptr, w_ptr_nx;
  logic [4:0]                 r_num, w_num_nx;
  logic [5*MAX_LETTERS-1:0]   r_word, w_word_nx;

  logic [127:0] r_key_down, w_key_down_nx;
  logic [8:0]   r_last_change, w_last_nx;
  logic         r_key_valid, w_kv_nx;
  logic         r_word_taken, w_taken_nx;
  logic         r_word_done, w_done_nx;
  logic [3:0]   r_letter_idx, w_lidx_nx;
  logic         r_busy;

  logic [4:0]             w_letter [MAX_LETTERS];
  logic [8:0]             w_code   [MAX_LETTERS];
  logic [MAX_LETTERS-1:0] w_valid;

  for (genvar g = 0; g < MAX_LETTERS; g++) begin : g_slot
    assign w_letter[g] = r_word[5*g +: 5];
    letter_to_scancode u_l2s (
      .i_idx   (w_letter[g]),
      .o_code  (w_code[g]),
      .o_valid (w_valid[g])
    );
  end

  // First usable slot at or after the pointer; invalid indices are skipped for free.
  logic          w_found;
  logic [SW-1:0] w_slot;
  always_comb begin
    w_found = 1'b0;
    w_slot  = '0;
    for (int i = MAX_LETTERS - 1; i >= 0; i--) begin
      if (w_valid[i] && (5'(i) >= r_ptr) && (5'(i) < r_num)) begin
        w_found = 1'b1;
        w_slot  = SW'(i);
      end
    end
  end

  logic [4:0] w_cur_letter, w_wrong_idx;
  assign w_cur_letter = w_letter[w_slot];
  assign w_wrong_idx  = (w_cur_letter == 5'd26) ? 5'd1 : w_cur_letter + 5'd1;

  // Which key the next press emits: typo chain first, then next letter, then space.
  logic [8:0] w_sel_code;
  key_kind_t  w_sel_kind;
  logic [4:0] w_sel_ptr;
  always_comb begin
    w_sel_code = SPACE;
    w_sel_kind = KK_SPACE;
    w_sel_ptr  = r_ptr;
    if (r_kind == KK_WRONG) begin
      w_sel_code = BACK;
      w_sel_kind = KK_BACK;
    end else if (r_kind == KK_BACK) begin
      w_sel_code = w_code[r_ptr[SW-1:0]];
      w_sel_kind = KK_LETTER;
    end else if (w_found) begin
      w_sel_ptr = 5'(w_slot);
      if (i_mistake_en && (r_mcnt == MC_LAST)) begin
        w_sel_code = KEY[w_wrong_idx];
        w_sel_kind = KK_WRONG;
      end else begin
        w_sel_code = w_code[w_slot];
        w_sel_kind = KK_LETTER;
      end
    end
  end

  logic w_press;
  always_comb begin
    w_state_nx    = r_state;
    w_kind_nx     = r_kind;
    w_cnt_nx      = r_cnt;
    w_mcnt_nx     = r_mcnt;
    w_ptr_nx      = r_ptr;
    w_num_nx      = r_num;
    w_word_nx     = r_word;
    w_key_down_nx = r_key_down;
    w_last_nx     = r_last_change;
    w_kv_nx       = 1'b0;
    w_taken_nx    = 1'b0;
    w_done_nx     = 1'b0;
    w_lidx_nx     = r_letter_idx;
    w_press       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_enable && i_word_valid) begin
          w_word_nx  = i_word;
          w_num_nx   = (i_wordnum > NUM_MAX) ? NUM_MAX : i_wordnum;
          w_taken_nx = 1'b1;
          w_lidx_nx  = 4'd0;
          w_ptr_nx   = 5'd0;
          w_kind_nx  = KK_SPACE;
          w_state_nx = ST_LOAD;
        end
      end
      ST_LOAD: w_press = 1'b1;
      ST_HOLD: begin
        if (r_cnt == 8'd0) begin
          w_key_down_nx = '0;
          w_kv_nx       = 1'b1;
          w_cnt_nx      = GAP_M1;
          w_state_nx    = ST_GAP;
          if (r_kind == KK_LETTER) begin
            w_ptr_nx  = r_ptr + 5'd1;
            w_lidx_nx = (r_letter_idx == 4'hF) ? 4'hF : r_letter_idx + 4'd1;
            w_mcnt_nx = (r_mcnt == MC_LAST) ? 8'd0 : r_mcnt + 8'd1;
          end else if (r_kind == KK_SPACE) begin
            w_done_nx  = 1'b1;
            w_state_nx = ST_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt - 8'd1;
        end
      end
      ST_GAP: begin
        if (r_cnt == 8'd0) w_press = 1'b1;
        else               w_cnt_nx = r_cnt - 8'd1;
      end
      default: w_state_nx = ST_IDLE;
    endcase

    if (w_press) begin
      w_key_down_nx                   = '0;
      w_key_down_nx[w_sel_code[6:0]]  = 1'b1;
      w_last_nx                       = w_sel_code;
      w_kv_nx                         = 1'b1;
      w_kind_nx                       = w_sel_kind;
      w_ptr_nx                        = w_sel_ptr;
      w_cnt_nx                        = HOLD_M1;
      w_state_nx                      = ST_HOLD;
    end

    // Losing enable aborts the word; a held key gets a clean release event.
    if (!i_enable) begin
      w_mcnt_nx = 8'd0;
      if (r_state != ST_IDLE) begin
        w_state_nx    = ST_IDLE;
        w_key_down_nx = '0;
        w_last_nx     = r_last_change;
        w_kv_nx       = (r_state == ST_HOLD);
        w_done_nx     = 1'b0;
        w_lidx_nx     = r_letter_idx;
      end
    end
  end

  always_ff @(posedge clk_div or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_kind        <= KK_LETTER;
      r_cnt         <= 8'd0;
      r_mcnt        <= 8'd0;
      r_ptr         <= 5'd0;
      r_num         <= 5'd0;
      r_word        <= '0;
      r_key_down    <= '0;
      r_last_change <= 9'd0;
      r_key_valid   <= 1'b0;
      r_word_taken  <= 1'b0;
      r_word_done   <= 1'b0;
      r_letter_idx  <= 4'd0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_kind        <= w_kind_nx;
      r_cnt         <= w_cnt_nx;
      r_mcnt        <= w_mcnt_nx;
      r_ptr         <= w_ptr_nx;
      r_num         <= w_num_nx;
      r_word        <= w_word_nx;
      r_key_down    <= w_key_down_nx;
      r_last_change <= w_last_nx;
      r_key_valid   <= w_kv_nx;
      r_word_taken  <= w_taken_nx;
      r_word_done   <= w_done_nx;
      r_letter_idx  <= w_lidx_nx;
      r_busy        <= (w_state_nx != ST_IDLE);
    end
  end

  assign o_key_down    = r_key_down;
  assign o_last_change = r_last_change;
  assign o_key_valid   = r_key_valid;
  assign o_word_taken  = r_word_taken;
  assign o_word_done   = r_word_done;
  assign o_letter_idx  = r_letter_idx;
  assign o_busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_ghost_typist.sv
// ============================================================================
// tb_ghost_typist: directed checks of ghost_typist timing, typo injection, abort and reset.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_ghost_typist;

  logic         clk_div = 1'b0;
  logic         rst;
  logic         i_enable;
  logic [74:0]  i_word;
  logic [4:0]   i_wordnum;
  logic         i_word_valid;
  logic         i_mistake_en;
  logic         o_word_taken;
  logic [127:0] o_key_down;
  logic [8:0]   o_last_change;
  logic         o_key_valid;
  logic [3:0]   o_letter_idx;
  logic         o_word_done;
  logic         o_busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_div = ~clk_div;

  ghost_typist dut (
    .clk_div       (clk_div),
    .rst           (rst),
    .i_enable      (i_enable),
    .i_word        (i_word),
    .i_wordnum     (i_wordnum),
    .i_word_valid  (i_word_valid),
    .i_mistake_en  (i_mistake_en),
    .o_word_taken  (o_word_taken),
    .o_key_down    (o_key_down),
    .o_last_change (o_last_change),
    .o_key_valid   (o_key_valid),
    .o_letter_idx  (o_letter_idx),
    .o_word_done   (o_word_done),
    .o_busy        (o_busy)
  );

  function automatic logic [127:0] kd(input int c);
    logic [127:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  function automatic logic [74:0] w3(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    logic [74:0] v;
    v        = '0;
    v[4:0]   = a;
    v[9:5]   = b;
    v[14:10] = c;
    return v;
  endfunction

  task automatic adv(input int n);
    repeat (n) @(negedge clk_div);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a word for exactly one edge; returns at the negedge after acceptance (T0).
  task automatic give(input logic [74:0] w, input logic [4:0] n);
    i_word       = w;
    i_wordnum    = n;
    i_word_valid = 1'b1;
    adv(1);
    i_word_valid = 1'b0;
  endtask

  logic [74:0] wtmp;

  initial begin
    rst          = 1'b1;
    i_enable     = 1'b0;
    i_word       = '0;
    i_wordnum    = 5'd0;
    i_word_valid = 1'b0;
    i_mistake_en = 1'b0;
    #2;
    chk("rst_key_down", o_key_down, '0);
    chk("rst_last", o_last_change, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_kv", o_key_valid, 0);
    adv(2);
    rst      = 1'b0;
    i_enable = 1'b1;
    adv(1);

    // "cat": presses 33,28,44,41 at T0+1/+9/+17/+25, done at T0+28
    give(w3(5'd3, 5'd1, 5'd20), 5'd3);
    chk("cat_taken", o_word_taken, 1);
    chk("cat_busy", o_busy, 1);
    chk("cat_lidx0", o_letter_idx, 0);
    adv(1);
    chk("cat_p1_kd", o_key_down, kd(33));
    chk("cat_p1_last", o_last_change, 33);
    chk("cat_p1_kv", o_key_valid, 1);
    chk("cat_taken_once", o_word_taken, 0);
    adv(1);
    chk("cat_hold_kv", o_key_valid, 0);
    chk("cat_hold_kd", o_key_down, kd(33));
    adv(2);
    chk("cat_r1_kd", o_key_down, '0);
    chk("cat_r1_kv", o_key_valid, 1);
    chk("cat_r1_last", o_last_change, 33);
    chk("cat_r1_lidx", o_letter_idx, 1);
    adv(5);
    chk("cat_p2_kd", o_key_down, kd(28));
    chk("cat_p2_kv", o_key_valid, 1);
    adv(8);
    chk("cat_p3_kd", o_key_down, kd(44));
    chk("cat_p3_lidx", o_letter_idx, 2);
    adv(8);
    chk("cat_sp_kd", o_key_down, kd(41));
    chk("cat_sp_lidx", o_letter_idx, 3);
    adv(2);
    chk("cat_done_early", o_word_done, 0);
    adv(1);
    chk("cat_done", o_word_done, 1);
    chk("cat_done_kd", o_key_down, '0);
    chk("cat_done_kv", o_key_valid, 1);
    chk("cat_done_last", o_last_change, 41);
    chk("cat_done_busy", o_busy, 0);
    adv(1);
    chk("cat_done_pulse", o_word_done, 0);

    // wordnum = 0: only SPACE
    give('0, 5'd0);
    chk("w0_taken", o_word_taken, 1);
    adv(1);
    chk("w0_sp_kd", o_key_down, kd(41));
    chk("w0_taken_once", o_word_taken, 0);
    adv(3);
    chk("w0_done", o_word_done, 1);
    chk("w0_done_kd", o_key_down, '0);

    // clear mistake counter, then typo on the 8th letter of "abcdefgh"
    i_enable = 1'b0;
    adv(1);
    i_enable     = 1'b1;
    i_mistake_en = 1'b1;
    wtmp = '0;
    for (int i = 0; i < 8; i++) wtmp[5*i +: 5] = 5'(i + 1);
    give(wtmp, 5'd8);
    adv(57);
    chk("typo_wrong_last", o_last_change, 67);
    chk("typo_wrong_kd", o_key_down, kd(67));
    chk("typo_wrong_lidx", o_letter_idx, 7);
    adv(3);
    chk("typo_wrong_rel", o_key_valid, 1);
    chk("typo_wrong_rel_lidx", o_letter_idx, 7);
    adv(5);
    chk("typo_back", o_last_change, 102);
    chk("typo_back_kd", o_key_down, kd(102));
    adv(8);
    chk("typo_fix", o_last_change, 51);
    adv(3);
    chk("typo_fix_lidx", o_letter_idx, 8);
    adv(8);
    chk("typo_done", o_word_done, 1);

    // 7 x 'a' then 'z': typo of z wraps to a
    wtmp = '0;
    for (int i = 0; i < 7; i++) wtmp[5*i +: 5] = 5'd1;
    wtmp[39:35] = 5'd26;
    give(wtmp, 5'd8);
    adv(57);
    chk("wrap_wrong", o_last_change, 28);
    adv(8);
    chk("wrap_back", o_last_change, 102);
    adv(8);
    chk("wrap_fix", o_last_change, 26);
    adv(11);
    chk("wrap_done", o_word_done, 1);
    chk("wrap_lidx", o_letter_idx, 8);

    i_mistake_en = 1'b0;
    i_enable     = 1'b0;
    adv(1);
    i_enable = 1'b1;

    // enable drops while 'c' is held
    give(w3(5'd3, 5'd1, 5'd20), 5'd3);
    adv(1);
    chk("abort_held", o_key_down, kd(33));
    adv(1);
    i_enable = 1'b0;
    adv(1);
    chk("abort_kd", o_key_down, '0);
    chk("abort_last", o_last_change, 33);
    chk("abort_kv", o_key_valid, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_done", o_word_done, 0);
    i_word_valid = 1'b1;
    adv(2);
    chk("abort_no_accept", o_word_taken, 0);
    chk("abort_idle_busy", o_busy, 0);
    chk("abort_idle_kv", o_key_valid, 0);
    i_word_valid = 1'b0;
    i_enable     = 1'b1;
    adv(1);

    // index 27 in slot 1 is skipped without costing a key slot
    give(w3(5'd1, 5'd27, 5'd2), 5'd3);
    adv(1);
    chk("skip_p0", o_key_down, kd(28));
    adv(8);
    chk("skip_p2_kd", o_key_down, kd(50));
    chk("skip_p2_last", o_last_change, 50);
    adv(8);
    chk("skip_sp", o_key_down, kd(41));
    adv(3);
    chk("skip_done", o_word_done, 1);
    chk("skip_lidx", o_letter_idx, 2);

    // asynchronous reset while a key is held
    give(w3(5'd3, 5'd1, 5'd20), 5'd3);
    adv(1);
    chk("rstm_pre_kv", o_key_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstm_kd", o_key_down, '0);
    chk("rstm_kv", o_key_valid, 0);
    chk("rstm_last", o_last_change, 0);
    chk("rstm_busy", o_busy, 0);
    #1;
    rst = 1'b0;
    adv(3);
    chk("rstm_after_busy", o_busy, 0);
    chk("rstm_after_kv", o_key_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
